aig_tt_sweeper: RTL and testbench

Sequential truth-table sweeper that sits directly upstream of a combinational MiniAig netlist. It drives every input pattern onto the netlist's primary inputs, samples the single primary output, and assembles the full truth table. It then compares the table against a golden table and reports the result with a start/done handshake. It is used to check resynthesised netlists for equivalence on-chip and in simulation.

---
 rtl/aig_tt_sweeper.sv | 149 ++++++++++++++
 tb/tb_aig_tt_sweeper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aig_tt_sweeper.sv
// Truth-table sweeper: drives every pattern onto a combinational netlist, collects
// the single primary output into a truth table and compares it with a golden table.
module aig_tt_sweeper #(
    parameter int NUM_PI = 5,
    parameter int SETTLE = 0,
    localparam int TT_W = 1 << NUM_PI
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TT_W-1:0]   golden,
    input  logic              po_in,
    output logic [NUM_PI-1:0] pi_vec,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic              match,
    output logic [NUM_PI:0]   mismatch_cnt,
    output logic [NUM_PI-1:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [NUM_PI-1:0] IDX_ONE    = NUM_PI'(1);
    localparam logic [NUM_PI-1:0] IDX_LAST   = '1;
    localparam logic [NUM_PI:0]   CNT_ONE    = (NUM_PI + 1)'(1);
    localparam logic [3:0]        SETTLE_END = 4'(SETTLE);

    state_t            state_q, state_d;
    logic [NUM_PI-1:0] idx_q, idx_d;
    logic [3:0]        settle_q, settle_d;
    logic [TT_W-1:0]   golden_q, golden_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [NUM_PI:0]   cnt_q, cnt_d;
    logic [NUM_PI-1:0] ff_q, ff_d;
    logic              match_q, match_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic for the sweep controller and result registers
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        golden_d = golden_q;
        tt_d     = tt_q;
        cnt_d    = cnt_q;
        ff_d     = ff_q;
        match_d  = match_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    settle_d = 4'd0;
                    tt_d     = '0;
                    cnt_d    = '0;
                    ff_d     = '0;
                    match_d  = 1'b0;
                    golden_d = golden;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // abort beats a sample landing in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    match_d = 1'b0;
                end else if (settle_q != SETTLE_END) begin
                    settle_d = settle_q + 4'd1;
                end else begin
                    tt_d[idx_q] = po_in;
                    if (po_in != golden_q[idx_q]) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == '0) begin
                            ff_d = idx_q;
                        end else begin
                            ff_d = ff_q;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (cnt_d == '0);
                    end else begin
                        idx_d    = idx_q + IDX_ONE;
                        settle_d = 4'd0;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= 4'd0;
            golden_q <= '0;
            tt_q     <= '0;
            cnt_q    <= '0;
            ff_q     <= '0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            golden_q <= golden_d;
            tt_q     <= tt_d;
            cnt_q    <= cnt_d;
            ff_q     <= ff_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pi_vec       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tt           = tt_q;
    assign match        = match_q;
    assign mismatch_cnt = cnt_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// Bench for aig_tt_sweeper: a SETTLE=0 instance on a combinational netlist and a
// SETTLE=2 instance on a registered one, checked against table and random vectors.
module tb_aig_tt_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [31:0] golden = 32'd0;
    logic        po0, po2 = 1'b0;
    logic [4:0]  pv0, pv2, ff0, ff2;
    logic        busy0, done0, match0, busy2, done2, match2;
    logic [31:0] tt0, tt2;
    logic [5:0]  cnt0, cnt2;

    int          src_mode = 0;
    logic [31:0] src_tt = 32'd0;
    int          n_chk = 0, n_fail = 0;

    logic        snap_busy, snap_done, snap_match;
    logic [31:0] snap_tt;
    logic [5:0]  snap_cnt;
    logic [4:0]  snap_ff, snap_pv;

    always #5 clk = ~clk;

    function automatic logic netf(input logic [4:0] p);
        return (p[0] & p[1]) | (p[2] & p[3]);
    endfunction

    assign po0 = (src_mode == 0) ? netf(pv0) : src_tt[pv0];

    always @(posedge clk) po2 <= netf(pv2);

    aig_tt_sweeper #(.NUM_PI(5), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .golden(golden),
        .po_in(po0), .pi_vec(pv0), .busy(busy0), .done(done0), .tt(tt0),
        .match(match0), .mismatch_cnt(cnt0), .first_fail(ff0)
    );

    aig_tt_sweeper #(.NUM_PI(5), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .golden(golden),
        .po_in(po2), .pi_vec(pv2), .busy(busy2), .done(done2), .tt(tt2),
        .match(match2), .mismatch_cnt(cnt2), .first_fail(ff2)
    );

    typedef struct {
        int          which;
        int          mode;
        logic [31:0] src;
        logic [31:0] gold;
        int          exp_cyc;
        logic [31:0] exp_tt;
        logic        exp_match;
        int          exp_cnt;
        int          exp_ff;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Table of the netlist function, built from its boolean definition
    function automatic logic [31:0] func_table();
        logic [31:0] t;
        t = 32'd0;
        for (int k = 0; k < 32; k++) t[k] = netf(5'(k));
        return t;
    endfunction

    // Reference comparison: count differing bits and lowest differing index
    task automatic ref_cmp(input logic [31:0] t, input logic [31:0] g,
                           output int cnt, output int ff);
        cnt = 0;
        ff  = 0;
        for (int k = 0; k < 32; k++) begin
            if (t[k] != g[k]) begin
                if (cnt == 0) ff = k;
                cnt++;
            end
        end
    endtask

    // act_k: 0 none, 1 abort, 2 reset, 3 extra start; applied in cycle act_c
    task automatic sweep(input int which, input logic [31:0] gold, input int act_c,
                         input int act_k, output int done_c);
        int s, c, lim;
        bit pv_ok;
        logic d, b;
        logic [4:0] pv;
        s   = (which == 0) ? 0 : 2;
        lim = 32 * (s + 1) + 12;
        @(negedge clk);
        golden = gold;
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        golden = ~gold;
        c = 1;
        done_c = -1;
        pv_ok = 1'b1;
        while (c <= lim) begin
            d  = (which == 0) ? done0 : done2;
            b  = (which == 0) ? busy0 : busy2;
            pv = (which == 0) ? pv0 : pv2;
            if (d) begin
                done_c = c;
                break;
            end
            if (act_k != 0 && c == act_c + 1) begin
                snap_busy = busy0; snap_done = done0; snap_match = match0;
                snap_tt = tt0; snap_cnt = cnt0; snap_ff = ff0; snap_pv = pv0;
            end
            if (b && int'(pv) != (c - 1) / (s + 1)) pv_ok = 1'b0;
            if (c == act_c) begin
                case (act_k)
                    1: abort0 = 1'b1;
                    2: rst = 1'b1;
                    3: start0 = 1'b1;
                    default: ;
                endcase
            end
            @(posedge clk);
            #1;
            abort0 = 1'b0;
            rst    = 1'b0;
            start0 = 1'b0;
            c++;
        end
        chk("pi_vec_sequence", 64'(pv_ok), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int dc;
        src_mode = v.mode;
        src_tt   = v.src;
        sweep(v.which, v.gold, 0, 0, dc);
        chk("done_cycle", 64'(dc), 64'(v.exp_cyc));
        if (v.which == 0) begin
            chk("busy_at_done", 64'(busy0), 64'd0);
            chk("tt", 64'(tt0), 64'(v.exp_tt));
            chk("match", 64'(match0), 64'(v.exp_match));
            chk("mismatch_cnt", 64'(cnt0), 64'(v.exp_cnt));
            chk("first_fail", 64'(ff0), 64'(v.exp_ff));
        end else begin
            chk("busy_at_done_s2", 64'(busy2), 64'd0);
            chk("tt_s2", 64'(tt2), 64'(v.exp_tt));
            chk("match_s2", 64'(match2), 64'(v.exp_match));
            chk("mismatch_cnt_s2", 64'(cnt2), 64'(v.exp_cnt));
            chk("first_fail_s2", 64'(ff2), 64'(v.exp_ff));
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'((which_done(v.which))), 64'd0);
        chk("match_held", 64'((v.which == 0) ? match0 : match2), 64'(v.exp_match));
    endtask

    function automatic logic which_done(input int which);
        return (which == 0) ? done0 : done2;
    endfunction

    initial begin
        vec_t tbl[5];
        vec_t rv;
        logic [31:0] ft;
        int dc, ec, ef;

        ft = func_table();
        tbl[0] = '{0, 0, 32'd0, 32'hF888F888, 33, 32'hF888F888, 1'b1, 0, 0};
        tbl[1] = '{0, 0, 32'd0, 32'hF888F889, 33, 32'hF888F888, 1'b0, 1, 0};
        tbl[2] = '{0, 0, 32'd0, 32'h0888F888, 33, 32'hF888F888, 1'b0, 4, 28};
        tbl[3] = '{0, 1, 32'hFFFFFFFF, 32'h00000000, 33, 32'hFFFFFFFF, 1'b0, 32, 0};
        tbl[4] = '{2, 0, 32'd0, 32'hF888F888, 97, 32'hF888F888, 1'b1, 0, 0};
        chk("func_table", 64'(ft), 64'hF888F888);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'({busy0, busy2}), 64'd0);
        chk("rst_done", 64'({done0, done2}), 64'd0);
        chk("rst_tt", 64'({tt0, tt2}), 64'd0);
        chk("rst_misc", 64'({match0, cnt0, ff0, pv0, match2, cnt2, ff2, pv2}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // abort in cycle 10: samples 0..8 kept, no done
        src_mode = 0;
        sweep(0, 32'hF888F888, 10, 1, dc);
        chk("abort_busy", 64'(snap_busy), 64'd0);
        chk("abort_tt", 64'(snap_tt), 64'h00000088);
        chk("abort_match", 64'(snap_match), 64'd0);
        chk("abort_no_done", 64'(dc), 64'(-1));
        chk("abort_tt_held", 64'(tt0), 64'h00000088);
        run_vec(tbl[0]);

        // reset in cycle 20 clears everything the next cycle
        sweep(0, 32'hF888F889, 20, 2, dc);
        chk("midrst_outputs", 64'({snap_busy, snap_done, snap_match, snap_cnt, snap_ff, snap_pv}), 64'd0);
        chk("midrst_tt", 64'(snap_tt), 64'd0);
        chk("midrst_no_done", 64'(dc), 64'(-1));

        // start while busy is ignored
        sweep(0, 32'hF888F888, 15, 3, dc);
        chk("start_busy_done_cycle", 64'(dc), 64'd33);
        chk("start_busy_tt", 64'(tt0), 64'hF888F888);
        @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            rv.which = 0;
            rv.mode  = 1;
            rv.src   = $urandom;
            if (i % 2 == 1) rv.gold = $urandom;
            else rv.gold = rv.src ^ (32'd1 << $urandom_range(31, 0));
            ref_cmp(rv.src, rv.gold, ec, ef);
            rv.exp_cyc   = 33;
            rv.exp_tt    = rv.src;
            rv.exp_cnt   = ec;
            rv.exp_ff    = ef;
            rv.exp_match = (ec == 0);
            run_vec(rv);
        end

        rv = tbl[4];
        rv.gold = $urandom;
        ref_cmp(ft, rv.gold, ec, ef);
        rv.exp_cnt   = ec;
        rv.exp_ff    = ef;
        rv.exp_match = (ec == 0);
        run_vec(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
